awg_rd_stream: RTL and testbench

AWG_RD_STREAM -- requirements
Module: awg_rd_stream

---
 rtl/awg_rd_stream_if.sv | 29 ++
 rtl/awg_rd_stream.sv | 97 +++++++++
 tb/tb_awg_rd_stream.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/awg_rd_stream_if.sv
// awg_rd_stream_if: control, ic_ram read port and sample stream of the AWG read streamer.
interface awg_rd_stream_if #(
    parameter int ram_dw = 128,
    parameter int ram_aw = 9,
    parameter int smp_w  = 16
);
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [ram_aw-1:0] start_addr;
    logic [ram_aw-1:0] end_addr;
    logic [ram_aw-1:0] addrb;
    logic [ram_dw-1:0] doutb;
    logic [smp_w-1:0]  smp_data;
    logic              smp_valid;
    logic              smp_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, stop, loop_en, start_addr, end_addr, doutb, smp_ready,
        output addrb, smp_data, smp_valid, busy, done
    );

    modport slave (
        output start, stop, loop_en, start_addr, end_addr, doutb, smp_ready,
        input  addrb, smp_data, smp_valid, busy, done
    );
endinterface

// File: rtl/awg_rd_stream.sv
// awg_rd_stream: streams ic_ram words from start_addr to end_addr as lane-ordered samples.
module awg_rd_stream #(
    parameter int ram_dw = 128,
    parameter int ram_aw = 9,
    parameter int smp_w  = 16
) (
    input logic clk,
    input logic rst,
    awg_rd_stream_if.master bus
);
    localparam int l  = ram_dw / smp_w;
    localparam int lw = l > 1 ? $clog2(l) : 1;

    logic              busy_q, more_q, loop_q, rd_v, rd_last, done_q;
    logic [ram_aw-1:0] addr_q, start_q, end_q;
    logic [ram_dw-1:0] word_q [2];
    logic [1:0]        last_q;
    logic              wp, rp;
    logic [1:0]        cnt, cnt_n;
    logic [lw-1:0]     lane;
    logic              valid, lane_end, xfer, pop, at_end, take, go, fin;
    logic [ram_dw-1:0] head;

    always_comb begin
        valid    = cnt != 2'd0;
        head     = word_q[rp];
        lane_end = lane == lw'(l - 1);
        xfer     = valid & bus.smp_ready;
        pop      = xfer & lane_end;
        cnt_n    = cnt + {1'b0, rd_v} - {1'b0, pop};
        at_end   = addr_q == end_q;
        // a read is only committed if its word is guaranteed a free slot on arrival
        take     = busy_q & more_q & (cnt_n < 2'd2);
        go       = bus.start & ~busy_q & ~bus.stop;
        fin      = pop & last_q[rp];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            more_q  <= 1'b0;
            loop_q  <= 1'b0;
            rd_v    <= 1'b0;
            rd_last <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            start_q <= '0;
            end_q   <= '0;
            last_q  <= '0;
            wp      <= 1'b0;
            rp      <= 1'b0;
            cnt     <= '0;
            lane    <= '0;
        end else if (bus.stop | fin) begin
            busy_q <= 1'b0;
            more_q <= 1'b0;
            rd_v   <= 1'b0;
            done_q <= fin & ~bus.stop;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= '0;
            lane   <= '0;
        end else begin
            done_q  <= 1'b0;
            rd_v    <= take;
            rd_last <= take & at_end & ~loop_q;
            cnt     <= cnt_n;
            if (go) begin
                busy_q  <= 1'b1;
                more_q  <= 1'b1;
                addr_q  <= bus.start_addr;
                start_q <= bus.start_addr;
                end_q   <= bus.end_addr;
                loop_q  <= bus.loop_en;
            end
            if (take) begin
                addr_q <= at_end ? (loop_q ? start_q : addr_q) : addr_q + 1'b1;
                more_q <= ~(at_end & ~loop_q);
            end
            if (rd_v) begin
                word_q[wp] <= bus.doutb;
                last_q[wp] <= rd_last;
                wp         <= ~wp;
            end
            if (xfer)
                lane <= lane_end ? '0 : lane + 1'b1;
            if (pop)
                rp <= ~rp;
        end
    end

    assign bus.addrb     = addr_q;
    assign bus.smp_valid = valid;
    assign bus.smp_data  = valid ? head[lane*smp_w +: smp_w] : '0;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_awg_rd_stream.sv
// tb_awg_rd_stream: randomized-ready bench comparing the sample stream with an address-sequence model.
module tb_awg_rd_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    awg_rd_stream_if #(.ram_dw(128), .ram_aw(9), .smp_w(16)) bus ();
    awg_rd_stream #(.ram_dw(128), .ram_aw(9), .smp_w(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [127:0] mem [512];
    always @(posedge clk) bus.doutb <= mem[bus.addrb];

    int checks = 0, failures = 0;
    int xfers, done_cnt, vcyc, mode;
    logic mon_en = 1'b0;
    logic stall_v = 1'b0;
    logic [15:0] stall_d;
    logic [15:0] exp_q [$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mode == 0) bus.smp_ready = 1'b1;
        else if (mode == 1) bus.smp_ready = ~bus.smp_ready;
        else bus.smp_ready = 1'($urandom_range(1));
    end

    always @(negedge clk) if (mon_en) begin
        if (bus.done) begin
            done_cnt++;
            check("done_valid", 32'(bus.smp_valid), 0);
            check("done_busy", 32'(bus.busy), 0);
        end
        if (bus.smp_valid) begin
            vcyc++;
            if (stall_v) check("stall_hold", 32'(bus.smp_data), 32'(stall_d));
            if (bus.smp_ready) begin
                logic [15:0] e;
                e = 16'hdead;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                xfers++;
                check("smp", 32'(bus.smp_data), 32'(e));
            end
        end
        stall_v = bus.smp_valid & ~bus.smp_ready;
        stall_d = bus.smp_data;
    end

    task automatic clear();
        exp_q.delete();
        xfers = 0;
        done_cnt = 0;
        vcyc = 0;
    endtask

    task automatic load(int s, int e, int reps);
        for (int r = 0; r < reps; r++) begin
            int a = s;
            forever begin
                for (int j = 0; j < 8; j++) exp_q.push_back(16'(8 * a + j));
                if (a == e) break;
                a = (a + 1) % 512;
            end
        end
    endtask

    task automatic do_start(int s, int e, bit lp);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.start_addr = 9'(s);
        bus.end_addr = 9'(e);
        bus.loop_en = lp;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.start_addr = 9'($urandom);
        bus.end_addr = 9'($urandom);
        bus.loop_en = 1'($urandom);
        check("start_busy", 32'(bus.busy), 1);
        check("start_addrb", 32'(bus.addrb), 32'(s));
        @(posedge clk); #1;
        check("lat_early", 32'(bus.smp_valid), 0);
        @(posedge clk); #1;
        check("lat_first", 32'(bus.smp_valid), 1);
    endtask

    task automatic wait_xfers(int n, int budget);
        int c = 0;
        while (xfers < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check("xfer_reached", 32'(xfers >= n), 1);
    endtask

    task automatic wait_done(int budget, int n);
        int c = 0;
        while (done_cnt == 0 && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check("done_seen", 32'(done_cnt != 0), 1);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 32'(done_cnt), 1);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_valid", 32'(bus.smp_valid), 0);
        check("idle_data", 32'(bus.smp_data), 0);
        check("xfer_count", 32'(xfers), 32'(n));
        check("exp_left", 32'(exp_q.size()), 0);
    endtask

    task automatic check_reset();
        check("rst_addrb", 32'(bus.addrb), 0);
        check("rst_data", 32'(bus.smp_data), 0);
        check("rst_valid", 32'(bus.smp_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 512; k++)
            for (int j = 0; j < 8; j++) mem[k][16*j +: 16] = 16'(8 * k + j);
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.loop_en = 1'b0;
        bus.start_addr = '0;
        bus.end_addr = '0;
        bus.smp_ready = 1'b1;
        mode = 0;
        clear();
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;
        mon_en = 1'b1;

        load(0, 3, 1);
        do_start(0, 3, 0);
        wait_done(200, 32);
        check("no_bubble", 32'(vcyc), 32);

        clear();
        mode = 1;
        load(0, 3, 1);
        do_start(0, 3, 0);
        wait_done(400, 32);

        clear();
        mode = 0;
        load(2, 3, 3);
        do_start(2, 3, 1);
        wait_xfers(40, 200);
        check("loop_no_bubble", 32'(vcyc), 32'(xfers));
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        check("stop_valid", 32'(bus.smp_valid), 0);
        check("stop_busy", 32'(bus.busy), 0);
        repeat (5) @(posedge clk);
        #1;
        check("stop_no_done", 32'(done_cnt), 0);
        clear();
        load(0, 0, 1);
        do_start(0, 0, 0);
        wait_done(200, 8);

        clear();
        mode = 2;
        load(510, 1, 1);
        do_start(510, 1, 0);
        wait_done(1000, 32);

        clear();
        load(5, 5, 1);
        do_start(5, 5, 0);
        bus.start = 1'b1;
        bus.start_addr = 9'd100;
        bus.end_addr = 9'd200;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(400, 8);

        clear();
        mode = 0;
        load(0, 3, 1);
        do_start(0, 3, 0);
        wait_xfers(12, 200);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset();
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_done", 32'(done_cnt), 0);
        check("rst_idle_valid", 32'(bus.smp_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
